// File: rtl/data_consuming_block_if.sv
// Upstream valid/ready byte channel into data_consuming_block.
// The producer drives master; the consumer uses slave.
interface data_consuming_block_if;
  logic       valid_in;
  logic [7:0] data_in;
  logic       ready_out;

  modport master (
    output valid_in,
    output data_in,
    input  ready_out
  );

  modport slave (
    input  valid_in,
    input  data_in,
    output ready_out
  );
endinterface

// File: rtl/data_consuming_block.sv
// Far-end sink: buffers upstream bytes in a small FIFO, drains them at a throttled rate and
// checks that drained bytes form a +1 (mod 256) sequence.
module data_consuming_block #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DRAIN_DIV = 3,
  parameter int unsigned LOCK_CNT  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  data_consuming_block_if.slave     up,
  input  logic                      drain_en,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic [15:0]               rx_count,
  output logic [15:0]               err_count,
  output logic                      seq_err,
  output logic                      sync_ok,
  output logic [7:0]                last_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;
  localparam int unsigned GW = $clog2(LOCK_CNT + 1);

  localparam logic [AW:0]   LevelFull = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] ThrMax    = CW'(DRAIN_DIV - 1);
  localparam logic [GW-1:0] GoodLast  = GW'(LOCK_CNT - 1);

  typedef enum logic [1:0] {StHunt, StLock, StResync} state_e;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [CW-1:0] thr_q;

  state_e        state_q;
  logic [7:0]    exp_q;
  logic [GW-1:0] good_q;
  logic [15:0]   rx_q, err_q;
  logic          seq_err_q;
  logic [7:0]    last_q;

  logic       push, thr_hit, pop, mismatch;
  logic [7:0] pop_word;

  // ready depends only on registered level, never on valid_in
  assign up.ready_out = (level_q != LevelFull);
  assign push         = up.valid_in && up.ready_out;
  assign thr_hit      = drain_en && (thr_q == ThrMax);
  assign pop          = thr_hit && (level_q != '0);
  assign pop_word     = mem_q[rd_ptr_q];
  assign mismatch     = (state_q != StHunt) && (pop_word != exp_q);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= up.data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      thr_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      // throttle wraps on its last phase even when there is nothing to pop
      if (drain_en) thr_q <= thr_hit ? '0 : thr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StHunt;
      exp_q     <= '0;
      good_q    <= '0;
      rx_q      <= '0;
      err_q     <= '0;
      seq_err_q <= 1'b0;
      last_q    <= '0;
    end else if (pop) begin
      last_q <= pop_word;
      exp_q  <= pop_word + 8'd1;
      if (rx_q != 16'hFFFF) rx_q <= rx_q + 16'd1;
      if (mismatch) begin
        seq_err_q <= 1'b1;
        if (err_q != 16'hFFFF) err_q <= err_q + 16'd1;
      end
      unique case (state_q)
        StHunt: state_q <= StLock;
        StLock: begin
          if (mismatch) begin
            good_q  <= '0;
            state_q <= StResync;
          end
        end
        StResync: begin
          if (mismatch) begin
            good_q <= '0;
          end else if (good_q == GoodLast) begin
            good_q  <= '0;
            state_q <= StLock;
          end else begin
            good_q <= good_q + 1'b1;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

  assign fifo_level = level_q;
  assign rx_count   = rx_q;
  assign err_count  = err_q;
  assign seq_err    = seq_err_q;
  assign sync_ok    = (state_q == StLock);
  assign last_data  = last_q;

endmodule

// File: tb/tb_data_consuming_block.sv
// Bench for data_consuming_block: two instances (DRAIN_DIV=3 and DRAIN_DIV=1) share stimulus and
// are compared every cycle against a queue-based reference model, plus directed sequences.
module tb_data_consuming_block;

  localparam int Depth = 4;
  localparam int LockN = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       v, de;
  logic [7:0] d;

  int n_cmp = 0;
  int n_bad = 0;

  data_consuming_block_if bus3 ();
  data_consuming_block_if bus1 ();

  assign bus3.valid_in = v;
  assign bus3.data_in  = d;
  assign bus1.valid_in = v;
  assign bus1.data_in  = d;

  logic [2:0]  lvl3, lvl1;
  logic [15:0] rx3, rx1, err3, err1;
  logic        se3, se1, so3, so1;
  logic [7:0]  last3, last1;

  data_consuming_block #(.DEPTH(4), .DRAIN_DIV(3), .LOCK_CNT(2)) u_dut3 (
    .clk(clk), .rst(rst), .up(bus3), .drain_en(de), .fifo_level(lvl3), .rx_count(rx3),
    .err_count(err3), .seq_err(se3), .sync_ok(so3), .last_data(last3)
  );

  data_consuming_block #(.DEPTH(4), .DRAIN_DIV(1), .LOCK_CNT(2)) u_dut1 (
    .clk(clk), .rst(rst), .up(bus1), .drain_en(de), .fifo_level(lvl1), .rx_count(rx1),
    .err_count(err1), .seq_err(se1), .sync_ok(so1), .last_data(last1)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 -> DRAIN_DIV=3 instance, index 1 -> DRAIN_DIV=1 instance
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int         m_thr[2], m_rx[2], m_err[2], m_run[2];
  bit         m_sticky[2], m_hunt[2], m_lock[2];
  logic [7:0] m_exp[2], m_last[2];

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_thr[i] = 0; m_rx[i] = 0; m_err[i] = 0; m_run[i] = 0;
      m_sticky[i] = 0; m_hunt[i] = 1; m_lock[i] = 0;
      m_exp[i] = 8'h00; m_last[i] = 8'h00;
    end
  endtask

  task automatic model_step(input int i);
    int div, sz;
    logic [7:0] w;
    bit do_push, do_pop;
    div = (i == 0) ? 3 : 1;
    sz  = (i == 0) ? q0.size() : q1.size();
    do_push = v && (sz < Depth);
    do_pop  = de && (m_thr[i] == div - 1) && (sz > 0);
    if (de) m_thr[i] = (m_thr[i] + 1) % div;
    if (do_pop) begin
      if (i == 0) w = q0.pop_front();
      else        w = q1.pop_front();
      m_last[i] = w;
      m_rx[i] = (m_rx[i] < 65535) ? m_rx[i] + 1 : 65535;
      if (m_hunt[i]) begin
        m_hunt[i] = 0;
        m_lock[i] = 1;
      end else if (w != m_exp[i]) begin
        m_err[i] = (m_err[i] < 65535) ? m_err[i] + 1 : 65535;
        m_sticky[i] = 1;
        m_lock[i] = 0;
        m_run[i] = 0;
      end else if (!m_lock[i]) begin
        m_run[i]++;
        if (m_run[i] == LockN) m_lock[i] = 1;
      end
      m_exp[i] = w + 8'd1;
    end
    if (do_push) begin
      if (i == 0) q0.push_back(d);
      else        q1.push_back(d);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int i, input logic rdy, input logic [2:0] lvl,
                           input logic [15:0] rx, input logic [15:0] err, input logic se,
                           input logic so, input logic [7:0] last);
    int sz;
    sz = (i == 0) ? q0.size() : q1.size();
    chk($sformatf("m%0d.level", i),   32'(lvl),  32'(sz));
    chk($sformatf("m%0d.ready", i),   32'(rdy),  32'(sz != Depth));
    chk($sformatf("m%0d.rx", i),      32'(rx),   32'(m_rx[i]));
    chk($sformatf("m%0d.err", i),     32'(err),  32'(m_err[i]));
    chk($sformatf("m%0d.seq_err", i), 32'(se),   32'(m_sticky[i]));
    chk($sformatf("m%0d.sync_ok", i), 32'(so),   32'(m_lock[i]));
    chk($sformatf("m%0d.last", i),    32'(last), 32'(m_last[i]));
  endtask

  task automatic compare_all();
    check_dut(0, bus3.ready_out, lvl3, rx3, err3, se3, so3, last3);
    check_dut(1, bus1.ready_out, lvl1, rx1, err1, se1, so1, last1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".d3.level"}, 32'(lvl3), 0);
    chk({tag, ".d3.ready"}, 32'(bus3.ready_out), 1);
    chk({tag, ".d3.rx"},    32'(rx3), 0);
    chk({tag, ".d3.err"},   32'(err3), 0);
    chk({tag, ".d3.seq"},   32'(se3), 0);
    chk({tag, ".d3.sync"},  32'(so3), 0);
    chk({tag, ".d3.last"},  32'(last3), 0);
    chk({tag, ".d1.level"}, 32'(lvl1), 0);
    chk({tag, ".d1.ready"}, 32'(bus1.ready_out), 1);
    chk({tag, ".d1.rx"},    32'(rx1), 0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        de;
    logic [2:0]  lvl;
    logic        rdy;
    logic [15:0] rx;
    logic [7:0]  last;
    logic        sync;
  } vec_t;

  function automatic vec_t mk(logic vv, logic [7:0] dd, logic ee, logic [2:0] l, logic r,
                              logic [15:0] x, logic [7:0] la, logic s);
    vec_t t;
    t.v = vv; t.d = dd; t.de = ee; t.lvl = l; t.rdy = r; t.rx = x; t.last = la; t.sync = s;
    return t;
  endfunction

  vec_t       tbl[20];
  logic [7:0] seq4[5];
  logic       sync_exp[6];
  logic [7:0] pd;

  initial begin
    // Fill then throttled drain of words 1..5 on the DRAIN_DIV=3 instance
    tbl[0]  = mk(1, 8'd1, 0, 3'd1, 1, 16'd0, 8'd0, 0);
    tbl[1]  = mk(1, 8'd2, 0, 3'd2, 1, 16'd0, 8'd0, 0);
    tbl[2]  = mk(1, 8'd3, 0, 3'd3, 1, 16'd0, 8'd0, 0);
    tbl[3]  = mk(1, 8'd4, 0, 3'd4, 0, 16'd0, 8'd0, 0);
    tbl[4]  = mk(1, 8'd5, 0, 3'd4, 0, 16'd0, 8'd0, 0);
    tbl[5]  = mk(1, 8'd5, 1, 3'd4, 0, 16'd0, 8'd0, 0);
    tbl[6]  = mk(1, 8'd5, 1, 3'd4, 0, 16'd0, 8'd0, 0);
    tbl[7]  = mk(1, 8'd5, 1, 3'd3, 1, 16'd1, 8'd1, 1);
    tbl[8]  = mk(1, 8'd5, 1, 3'd4, 0, 16'd1, 8'd1, 1);
    tbl[9]  = mk(0, 8'd0, 1, 3'd4, 0, 16'd1, 8'd1, 1);
    tbl[10] = mk(0, 8'd0, 1, 3'd3, 1, 16'd2, 8'd2, 1);
    tbl[11] = mk(0, 8'd0, 1, 3'd3, 1, 16'd2, 8'd2, 1);
    tbl[12] = mk(0, 8'd0, 1, 3'd3, 1, 16'd2, 8'd2, 1);
    tbl[13] = mk(0, 8'd0, 1, 3'd2, 1, 16'd3, 8'd3, 1);
    tbl[14] = mk(0, 8'd0, 1, 3'd2, 1, 16'd3, 8'd3, 1);
    tbl[15] = mk(0, 8'd0, 1, 3'd2, 1, 16'd3, 8'd3, 1);
    tbl[16] = mk(0, 8'd0, 1, 3'd1, 1, 16'd4, 8'd4, 1);
    tbl[17] = mk(0, 8'd0, 1, 3'd1, 1, 16'd4, 8'd4, 1);
    tbl[18] = mk(0, 8'd0, 1, 3'd1, 1, 16'd4, 8'd4, 1);
    tbl[19] = mk(0, 8'd0, 1, 3'd0, 1, 16'd5, 8'd5, 1);

    rst = 1'b1; v = 1'b0; d = 8'h00; de = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 20; r++) begin
      v = tbl[r].v; d = tbl[r].d; de = tbl[r].de;
      step();
      chk($sformatf("tbl%0d.level", r), 32'(lvl3), 32'(tbl[r].lvl));
      chk($sformatf("tbl%0d.ready", r), 32'(bus3.ready_out), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d.rx", r),    32'(rx3), 32'(tbl[r].rx));
      chk($sformatf("tbl%0d.last", r),  32'(last3), 32'(tbl[r].last));
      chk($sformatf("tbl%0d.sync", r),  32'(so3), 32'(tbl[r].sync));
    end
    chk("tbl.err", 32'(err3), 0);

    // Wrap through FF->00 with simultaneous push/pop on the DRAIN_DIV=1 instance
    do_reset();
    de = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v = 1'b1; d = 8'hFD + 8'(k);
      step();
      if (k > 0) begin
        chk($sformatf("wrap%0d.level", k), 32'(lvl1), 1);
        chk($sformatf("wrap%0d.ready", k), 32'(bus1.ready_out), 1);
      end
    end
    v = 1'b0;
    step();
    chk("wrap.err",  32'(err1), 0);
    chk("wrap.sync", 32'(so1), 1);
    chk("wrap.last", 32'(last1), 32'h02);
    chk("wrap.rx",   32'(rx1), 6);

    // Single skip then resync after LOCK_CNT good words
    do_reset();
    seq4[0] = 8'd10; seq4[1] = 8'd11; seq4[2] = 8'd13; seq4[3] = 8'd14; seq4[4] = 8'd15;
    sync_exp[0] = 0; sync_exp[1] = 1; sync_exp[2] = 1;
    sync_exp[3] = 0; sync_exp[4] = 0; sync_exp[5] = 1;
    de = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v = (k < 5);
      d = (k < 5) ? seq4[k] : 8'h00;
      step();
      chk($sformatf("skip%0d.sync", k), 32'(so1), 32'(sync_exp[k]));
    end
    chk("skip.err", 32'(err1), 1);
    chk("skip.seq", 32'(se1), 1);

    // Asynchronous reset with three words buffered
    do_reset();
    de = 1'b0;
    for (int k = 0; k < 3; k++) begin
      v = 1'b1; d = 8'(k + 7);
      step();
    end
    chk("mid.level", 32'(lvl3), 3);
    rst = 1'b1;
    model_reset();
    #1;
    check_reset("mid");
    @(negedge clk);
    rst = 1'b0;
    v = 1'b1; d = 8'h40; de = 1'b1;
    step();
    v = 1'b0;
    repeat (4) step();
    chk("mid.err",  32'(err3), 0);
    chk("mid.sync", 32'(so3), 1);
    chk("mid.last", 32'(last3), 32'h40);
    chk("mid.rx",   32'(rx3), 1);

    // Random traffic, mostly in-sequence with occasional jumps and resets
    do_reset();
    pd = 8'($urandom);
    for (int c = 0; c < 800; c++) begin
      v  = ($urandom_range(0, 3) != 0);
      de = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) pd = 8'($urandom);
      d = pd;
      pd = pd + 8'd1;
      step();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
